regfile_operand_reader: RTL and testbench

REGFILE_OPERAND_READER -- requirements
Module: regfile_operand_reader

---
 rtl/regfile_operand_reader.sv | 116 +++++++++++
 tb/tb_regfile_operand_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_reader.sv
// Operand reader: regfile read with two-cycle writeback bypass, busy scoreboard and a one-entry output register.
// Latency is 1 cycle. req_ready_o drops on a busy source/rd, on flush, or when the output entry is stalled.
module regfile_operand_reader #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_WRITE_PORTS = 2,
  parameter bit ZERO_REG_ZERO  = 1'b1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [4:0]                               rs1_i,
  input  logic [4:0]                               rs2_i,
  input  logic [4:0]                               rd_i,
  input  logic                                     rd_we_i,
  output logic [1:0][4:0]                          raddr_o,
  input  logic [1:0][DATA_WIDTH-1:0]               rdata_i,
  input  logic [NR_WRITE_PORTS-1:0][4:0]           wb_waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wb_wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                wb_we_i,
  output logic                                     rsp_valid_o,
  input  logic                                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                    op_a_o,
  output logic [DATA_WIDTH-1:0]                    op_b_o
);

  logic [31:0]                               busy_q, busy_d;
  logic [NR_WRITE_PORTS-1:0]                 prev_we_q;
  logic [NR_WRITE_PORTS-1:0][4:0]            prev_waddr_q;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] prev_wdata_q;
  logic                                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]                     op_a_q, op_b_q;
  logic [DATA_WIDTH-1:0]                     sel_a, sel_b;
  logic                                      accept;

  assign raddr_o[0] = rs1_i;
  assign raddr_o[1] = rs2_i;

  function automatic logic wb_hit(input logic [4:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NR_WRITE_PORTS; i++) begin
      if (wb_we_i[i] && wb_waddr_i[i] == idx) hit = 1'b1;
    end
    return hit;
  endfunction

  // A register being written back this cycle is already resolved by the bypass.
  function automatic logic is_busy(input logic [4:0] idx);
    return busy_q[idx] && !wb_hit(idx);
  endfunction

  // Later assignments win: current set over previous set over rdata, high port over low port.
  function automatic logic [DATA_WIDTH-1:0] select_operand(input logic [4:0]            idx,
                                                           input logic [DATA_WIDTH-1:0] rf_val);
    logic [DATA_WIDTH-1:0] v;
    v = rf_val;
    for (int i = 0; i < NR_WRITE_PORTS; i++) begin
      if (prev_we_q[i] && prev_waddr_q[i] == idx) v = prev_wdata_q[i];
    end
    for (int i = 0; i < NR_WRITE_PORTS; i++) begin
      if (wb_we_i[i] && wb_waddr_i[i] == idx) v = wb_wdata_i[i];
    end
    if (ZERO_REG_ZERO && idx == 5'd0) v = '0;
    return v;
  endfunction

  assign sel_a = select_operand(rs1_i, rdata_i[0]);
  assign sel_b = select_operand(rs2_i, rdata_i[1]);

  assign req_ready_o = !flush_i && !is_busy(rs1_i) && !is_busy(rs2_i) &&
                       !(rd_we_i && is_busy(rd_i)) && (!rsp_valid_q || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NR_WRITE_PORTS; i++) begin
      if (wb_we_i[i]) busy_d[wb_waddr_i[i]] = 1'b0;
    end
    // Set after clear so a same-cycle set/clear of one index leaves it busy.
    if (accept && rd_we_i && (rd_i != 5'd0 || !ZERO_REG_ZERO)) busy_d[rd_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= '0;
      prev_we_q    <= '0;
      prev_waddr_q <= '0;
      prev_wdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      busy_q       <= busy_d;
      prev_we_q    <= wb_we_i;
      prev_waddr_q <= wb_waddr_i;
      prev_wdata_q <= wb_wdata_i;
      if (flush_i) begin
        rsp_valid_q <= 1'b0;
      end else if (accept) begin
        rsp_valid_q <= 1'b1;
        op_a_q      <= sel_a;
        op_b_q      <= sel_b;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Randomized and directed bench for regfile_operand_reader against an architectural-state model.
module tb_regfile_operand_reader;
  localparam int DW = 32;
  localparam int NW = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   flush_i, req_valid_i, req_ready_o, rd_we_i, rsp_valid_o, rsp_ready_i;
  logic [4:0]             rs1_i, rs2_i, rd_i;
  logic [1:0][4:0]        raddr_o;
  logic [1:0][DW-1:0]     rdata_i;
  logic [NW-1:0][4:0]     wb_waddr_i;
  logic [NW-1:0][DW-1:0]  wb_wdata_i;
  logic [NW-1:0]          wb_we_i;
  logic [DW-1:0]          op_a_o, op_b_o;

  regfile_operand_reader #(.DATA_WIDTH(DW), .NR_WRITE_PORTS(NW), .ZERO_REG_ZERO(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rd_we_i(rd_we_i),
    .raddr_o(raddr_o), .rdata_i(rdata_i),
    .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_we_i(wb_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o)
  );

  int checks = 0;
  int failures = 0;

  // arch: latest value of every register; arch_prev: what the external regfile shows (two cycles late).
  logic [DW-1:0] arch [32];
  logic [DW-1:0] arch_prev [32];
  bit            pend [32];
  bit            exp_valid;
  logic [DW-1:0] exp_a, exp_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_operand(input logic [4:0] idx);
    logic [DW-1:0] v;
    v = arch[idx];
    for (int i = 0; i < NW; i++) if (wb_we_i[i] && wb_waddr_i[i] == idx) v = wb_wdata_i[i];
    return (idx == 5'd0) ? '0 : v;
  endfunction

  function automatic bit m_busy(input logic [4:0] idx);
    bit b;
    b = pend[idx];
    for (int i = 0; i < NW; i++) if (wb_we_i[i] && wb_waddr_i[i] == idx) b = 1'b0;
    return b;
  endfunction

  function automatic bit m_ready();
    return !flush_i && !m_busy(rs1_i) && !m_busy(rs2_i) && !(rd_we_i && m_busy(rd_i)) &&
           (!exp_valid || rsp_ready_i);
  endfunction

  task automatic idle();
    flush_i = 0; req_valid_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0; rd_we_i = 0;
    rsp_ready_i = 1; wb_we_i = '0; wb_waddr_i = '0; wb_wdata_i = '0;
  endtask

  // Called just after a rising edge with inputs already set; returns just after the next rising edge.
  task automatic tick();
    bit            acc;
    logic [DW-1:0] na, nb;
    rdata_i[0] = arch_prev[rs1_i];
    rdata_i[1] = arch_prev[rs2_i];
    @(negedge clk_i);
    chk("raddr", 64'(raddr_o), 64'({rs2_i, rs1_i}));
    chk("req_ready", 64'(req_ready_o), 64'(m_ready()));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
    if (exp_valid) begin
      chk("op_a", 64'(op_a_o), 64'(exp_a));
      chk("op_b", 64'(op_b_o), 64'(exp_b));
    end
    acc = req_valid_i && m_ready();
    na  = m_operand(rs1_i);
    nb  = m_operand(rs2_i);
    @(posedge clk_i);
    if (flush_i) exp_valid = 0;
    else if (acc) begin exp_valid = 1; exp_a = na; exp_b = nb; end
    else if (rsp_ready_i) exp_valid = 0;
    for (int i = 0; i < NW; i++) if (wb_we_i[i]) pend[wb_waddr_i[i]] = 0;
    if (acc && rd_we_i && rd_i != 5'd0) pend[rd_i] = 1;
    if (flush_i) for (int r = 0; r < 32; r++) pend[r] = 0;
    for (int r = 0; r < 32; r++) arch_prev[r] = arch[r];
    for (int i = 0; i < NW; i++) if (wb_we_i[i]) arch[wb_waddr_i[i]] = wb_wdata_i[i];
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      arch[r] = $urandom;
      pend[r] = 0;
    end
    arch[0] = 32'hDEAD_BEEF;
    arch[3] = 32'h33;
    arch[4] = 32'h44;
    arch[7] = 32'h0;
    for (int r = 0; r < 32; r++) arch_prev[r] = arch[r];
    exp_valid = 0; exp_a = '0; exp_b = '0;
    idle();
    rdata_i = '0;
    #12;
    chk("rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_op_a", 64'(op_a_o), 64'd0);
    chk("rst_op_b", 64'(op_b_o), 64'd0);
    rsp_ready_i = 0;
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    rsp_ready_i = 1;
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;

    // Basic read from the regfile
    idle(); req_valid_i = 1; rs1_i = 3; rs2_i = 4;
    tick();
    chk("r22_valid", 64'(rsp_valid_o), 64'd1);
    chk("r22_a", 64'(op_a_o), 64'h33);
    chk("r22_b", 64'(op_b_o), 64'h44);

    // RAW hazard on x5 resolved by a writeback in the accepting cycle
    idle(); req_valid_i = 1; rs1_i = 1; rs2_i = 2; rd_i = 5; rd_we_i = 1;
    tick();
    idle(); req_valid_i = 1; rs1_i = 5; rs2_i = 2;
    tick();
    chk("r23_stall", 64'(req_ready_o), 64'd0);
    tick();
    wb_we_i[0] = 1; wb_waddr_i[0] = 5; wb_wdata_i[0] = 32'hABCD;
    tick();
    chk("r23_valid", 64'(rsp_valid_o), 64'd1);
    chk("r23_a", 64'(op_a_o), 64'hABCD);

    // Previous-cycle bypass over stale regfile data, then same-cycle port priority
    idle(); wb_we_i[0] = 1; wb_waddr_i[0] = 7; wb_wdata_i[0] = 32'h11;
    tick();
    idle(); req_valid_i = 1; rs1_i = 1; rs2_i = 7;
    tick();
    chk("r24_prev", 64'(op_b_o), 64'h11);
    idle(); req_valid_i = 1; rs1_i = 1; rs2_i = 7;
    wb_we_i = 2'b11; wb_waddr_i[0] = 7; wb_waddr_i[1] = 7;
    wb_wdata_i[0] = 32'h1; wb_wdata_i[1] = 32'h2;
    tick();
    chk("r24_prio", 64'(op_b_o), 64'h2);

    // x0 reads as zero even while written
    idle(); req_valid_i = 1; rs1_i = 0; rs2_i = 3;
    wb_we_i[0] = 1; wb_waddr_i[0] = 0; wb_wdata_i[0] = 32'hFF;
    tick();
    chk("r25_zero", 64'(op_a_o), 64'd0);

    // Output stall, then flush mid-stall
    idle(); req_valid_i = 1; rs1_i = 1; rs2_i = 2; rd_i = 9; rd_we_i = 1;
    tick();
    idle(); req_valid_i = 1; rs1_i = 3; rs2_i = 4; rsp_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r26_hold_v", 64'(rsp_valid_o), 64'd1);
      chk("r26_hold_a", 64'(op_a_o), 64'(exp_a));
    end
    flush_i = 1;
    tick();
    chk("r26_flush_v", 64'(rsp_valid_o), 64'd0);
    idle(); req_valid_i = 1; rs1_i = 9; rs2_i = 9; rsp_ready_i = 0;
    #1;
    chk("r26_busy_clr", 64'(req_ready_o), 64'd1);
    tick();

    // Random traffic over a small register window to force hazards and collisions
    for (int c = 0; c < 800; c++) begin
      idle();
      req_valid_i = ($urandom % 4) != 0;
      rs1_i       = 5'($urandom % 8);
      rs2_i       = 5'($urandom % 8);
      rd_i        = 5'($urandom % 8);
      rd_we_i     = $urandom % 2;
      rsp_ready_i = ($urandom % 4) != 0;
      flush_i     = ($urandom % 50) == 0;
      for (int i = 0; i < NW; i++) begin
        wb_we_i[i]    = ($urandom % 3) == 0;
        wb_waddr_i[i] = 5'($urandom % 8);
        wb_wdata_i[i] = $urandom;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
